// File: rtl/gon_pkg.sv
// Shared GON width and population defaults.
package gon_pkg;

  localparam int unsigned GON_ID_LEN    = 4;
  localparam int unsigned GON_COL_LEN   = 5;
  localparam int unsigned GON_VALUE_LEN = 32;
  localparam int unsigned GON_XBUS_NUMS = 12;
  localparam int unsigned GON_PE_NUMS   = 14;

endpackage

// File: rtl/gon_id_match.sv
// One scan-loaded master ID register plus the match compare that produces the master's ready.
module gon_id_match
  import gon_pkg::*;
#(
  parameter int unsigned ID_LEN = GON_ID_LEN
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_shift,
  input  logic [ID_LEN-1:0] i_scan,
  input  logic              i_ready,
  input  logic [ID_LEN-1:0] i_match_id,
  output logic [ID_LEN-1:0] o_id,
  output logic              o_ready
);

  logic [ID_LEN-1:0] r_id;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_id <= '0;
    end else if (i_shift) begin
      r_id <= i_scan;
    end
  end

  assign o_id    = r_id;
  assign o_ready = i_ready && (r_id == i_match_id);

endmodule

// File: rtl/gon_tag_bus.sv
// Tag-matched gather bus: ID-matched ready fan-out, lowest-index enabled data return.
// GON_BUS_PIPE_EN registers the return path (1-cycle latency); default is combinational.
module gon_tag_bus
  import gon_pkg::*;
#(
  parameter int unsigned MASTER_NUMS = GON_XBUS_NUMS,
  parameter int unsigned ID_LEN      = GON_ID_LEN,
  parameter int unsigned PASS_LEN    = GON_COL_LEN,
  parameter int unsigned VALUE_LEN   = GON_VALUE_LEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ID_LEN+PASS_LEN:0]    ready_tag,
  output logic [VALUE_LEN:0]          enable_value,
  output logic [PASS_LEN:0]           master_ready_tag   [MASTER_NUMS],
  input  logic [VALUE_LEN:0]          master_enable_data [MASTER_NUMS],
  input  logic                        set_id,
  input  logic [ID_LEN-1:0]           id_scan_in,
  output logic [ID_LEN-1:0]           id_scan_out
);

  logic                w_ready;
  logic [ID_LEN-1:0]   w_match_id;
  logic [PASS_LEN-1:0] w_pass;
  logic [ID_LEN-1:0]   w_id       [MASTER_NUMS];
  logic                w_ready_i  [MASTER_NUMS];
  logic [VALUE_LEN:0]  w_ret;

  assign {w_ready, w_match_id, w_pass} = ready_tag;

  for (genvar g = 0; g < MASTER_NUMS; g++) begin : g_master
    logic [ID_LEN-1:0] w_scan;

    if (g == 0) begin : g_head
      assign w_scan = id_scan_in;
    end else begin : g_link
      assign w_scan = w_id[g-1];
    end

    gon_id_match #(
      .ID_LEN(ID_LEN)
    ) u_match (
      .i_clk      (clk),
      .i_rst_n    (rst),
      .i_shift    (set_id),
      .i_scan     (w_scan),
      .i_ready    (w_ready),
      .i_match_id (w_match_id),
      .o_id       (w_id[g]),
      .o_ready    (w_ready_i[g])
    );

    assign master_ready_tag[g] = {w_ready_i[g], w_pass};
  end

  assign id_scan_out = w_id[MASTER_NUMS-1];

  // First enabled master wins; its enable bit doubles as the "already found" flag.
  always_comb begin
    w_ret = '0;
    for (int unsigned i = 0; i < MASTER_NUMS; i++) begin
      if (master_enable_data[i][VALUE_LEN] && !w_ret[VALUE_LEN]) begin
        w_ret = master_enable_data[i];
      end
    end
  end

`ifdef GON_BUS_PIPE_EN
  logic [VALUE_LEN:0] r_ret;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ret <= '0;
    end else begin
      r_ret <= w_ret;
    end
  end

  assign enable_value = r_ret;
`else
  assign enable_value = w_ret;
`endif

endmodule

// File: tb/tb_gon_tag_bus.sv
// Self-checking bench for gon_tag_bus (4 masters, 4-bit IDs, 5-bit pass tag, 32-bit data).
module tb_gon_tag_bus;

  localparam int N  = 4;
  localparam int IL = 4;
  localparam int PL = 5;
  localparam int VL = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rt_ready = 1'b0;
  logic [IL-1:0]     rt_match = '0;
  logic [PL-1:0]     rt_pass = '0;
  logic [IL+PL:0]    ready_tag;
  logic [VL:0]       enable_value;
  logic [PL:0]       master_ready_tag   [N];
  logic [VL:0]       master_enable_data [N];
  logic              set_id = 1'b0;
  logic [IL-1:0]     id_scan_in = '0;
  logic [IL-1:0]     id_scan_out;

  int total = 0;
  int bad   = 0;

  // Reference state: the ID every master should currently hold.
  int m_id [N];

  assign ready_tag = {rt_ready, rt_match, rt_pass};

  always #5 clk = ~clk;

  gon_tag_bus #(
    .MASTER_NUMS (N),
    .ID_LEN      (IL),
    .PASS_LEN    (PL),
    .VALUE_LEN   (VL)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ready_tag          (ready_tag),
    .enable_value       (enable_value),
    .master_ready_tag   (master_ready_tag),
    .master_enable_data (master_enable_data),
    .set_id             (set_id),
    .id_scan_in         (id_scan_in),
    .id_scan_out        (id_scan_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic shift_in(input int v);
    id_scan_in = v[IL-1:0];
    set_id = 1'b1;
    @(posedge clk);
    #1;
    set_id = 1'b0;
    for (int i = N - 1; i > 0; i--) m_id[i] = m_id[i-1];
    m_id[0] = v;
  endtask

  task automatic clear_en();
    for (int i = 0; i < N; i++) master_enable_data[i] = '0;
  endtask

  function automatic logic [VL:0] model_ret();
    for (int i = 0; i < N; i++)
      if (master_enable_data[i][VL]) return {1'b1, master_enable_data[i][VL-1:0]};
    return '0;
  endfunction

  task automatic check_fan(input string tag);
    logic r;
    #1;
    for (int i = 0; i < N; i++) begin
      r = rt_ready && (m_id[i] == int'(rt_match));
      chk($sformatf("%s_m%0d", tag, i), 64'(master_ready_tag[i]), 64'({r, rt_pass}));
    end
  endtask

  task automatic check_ret(input string tag);
    logic [VL:0] exp;
    exp = model_ret();
`ifdef GON_BUS_PIPE_EN
    @(posedge clk);
`endif
    #1;
    chk(tag, 64'(enable_value), 64'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) m_id[i] = 0;
    clear_en();
    #12;
    chk("reset_scan_out", 64'(id_scan_out), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Scan load: first ID shifted in lands in the last master.
    shift_in(3); shift_in(2); shift_in(1); shift_in(0);
    chk("scan_out_loaded", 64'(id_scan_out), 64'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("scan_out_hold", 64'(id_scan_out), 64'd3);
    for (int k = 0; k < N; k++) begin
      rt_ready = 1'b1; rt_match = k[IL-1:0]; rt_pass = 5'h0A;
      check_fan($sformatf("ids_k%0d", k));
    end

    // Unicast
    rt_ready = 1'b1; rt_match = 4'd2; rt_pass = 5'h15;
    clear_en();
    master_enable_data[2] = {1'b1, 32'hDEADBEEF};
    check_fan("unicast");
    chk("unicast_m2_ready", 64'(master_ready_tag[2]), 64'({1'b1, 5'h15}));
    check_ret("unicast_ret");
    chk("unicast_ret_const", 64'(enable_value), 64'({1'b1, 32'hDEADBEEF}));

    // Multicast with lowest-index priority: IDs {1,1,0,1}
    shift_in(1); shift_in(0); shift_in(1); shift_in(1);
    rt_ready = 1'b1; rt_match = 4'd1; rt_pass = 5'h03;
    clear_en();
    master_enable_data[1] = {1'b1, 32'd7};
    master_enable_data[3] = {1'b1, 32'd9};
    check_fan("multicast");
    check_ret("priority_ret");
    chk("priority_const", 64'(enable_value), 64'({1'b1, 32'd7}));

    // Idle
    rt_ready = 1'b0; rt_match = 4'd1;
    clear_en();
    check_fan("idle");
    check_ret("idle_ret");
    chk("idle_const", 64'(enable_value), 64'd0);

    // Async reset mid-cycle after loading 5..8
    shift_in(8); shift_in(7); shift_in(6); shift_in(5);
    chk("load58_scan_out", 64'(id_scan_out), 64'd8);
    master_enable_data[0] = {1'b1, 32'h1234};
    check_ret("pipe_1234");
    #3;
    rst = 1'b0;
    for (int i = 0; i < N; i++) m_id[i] = 0;
    #1;
    chk("async_scan_out", 64'(id_scan_out), 64'd0);
`ifdef GON_BUS_PIPE_EN
    chk("async_ret_clear", 64'(enable_value), 64'd0);
`else
    chk("async_ret_comb", 64'(enable_value), 64'({1'b1, 32'h1234}));
`endif
    rt_ready = 1'b1; rt_match = 4'd0; rt_pass = 5'h1F;
    check_fan("in_reset_all");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    check_fan("post_reset_all");
    clear_en();

    // Randomized traffic against the reference model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) shift_in(int'($urandom_range(0, 3)));
      rt_ready = 1'($urandom_range(0, 3) != 0);
      rt_match = 4'($urandom_range(0, 4));
      rt_pass  = 5'($urandom);
      for (int i = 0; i < N; i++)
        master_enable_data[i] = {1'($urandom_range(0, 2) == 0), 32'($urandom)};
      check_fan($sformatf("rnd%0d", it));
      check_ret($sformatf("rnd%0d_ret", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gon_tag_bus.md
Name: gon_tag_bus

Overview:
- Tag-matched gather bus for the global-on-chip network (GON).
- A requester presents {ready, tag}. Every master whose scan-loaded ID equals the ID field of the tag receives the ready and the forwarded tag bits.
- The enabled master's {enable, data} is returned to the requester.
- One instance serves as the row-level bus (ID = row tag, column tag forwarded) or as the column-level bus toward PEs (ID = column tag; masters use the ready bit only).

Parameters:
- MASTER_NUMS, 12: number of attached masters.
- ID_LEN, 4: width of the match ID and of each master's ID register.
- PASS_LEN, 5: tag bits forwarded to masters unchanged; must be at least 1.
- VALUE_LEN, 32: data width.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-low reset.
- ready_tag, input, 1+ID_LEN+PASS_LEN: {ready, match_id, pass_tag}, MSB first.
- enable_value, output, 1+VALUE_LEN: {enable, value} returned to the requester.
- master_ready_tag, output, MASTER_NUMS x (1+PASS_LEN) (unpacked array): per master {ready_i, pass_tag}.
- master_enable_data, input, MASTER_NUMS x (1+VALUE_LEN) (unpacked array): per master {enable_i, data_i}.
- set_id, input, 1: shift enable for the ID scan chain.
- id_scan_in, input, ID_LEN: scan chain input.
- id_scan_out, output, ID_LEN: scan chain output; equals the ID register of master MASTER_NUMS-1.

Behaviour:
- Reset (rst=0, asynchronous): all ID registers clear to 0. With GON_BUS_PIPE_EN, the output register also clears to 0.
- ID scan chain, on each posedge clk with set_id=1:
  - id[0] <= id_scan_in;
  - id[i] <= id[i-1] for i = 1..MASTER_NUMS-1.
  - With set_id=0 the registers hold.
  - Loading a full chain takes MASTER_NUMS cycles; the first ID shifted in ends in master MASTER_NUMS-1.
- Ready fan-out (combinational):
  - ready_i = ready AND (id[i] == match_id).
  - pass_tag is driven to every master regardless of match.
  - Several masters sharing one ID all receive ready (multicast).
  - ready=0 forces every ready_i to 0.
- Data return (combinational):
  - enable = OR over all enable_i.
  - value = data of the lowest-index master with enable_i=1.
  - No enable set: enable=0 and value=0.
  - Masters are required to raise enable only in a cycle where they see ready. The bus does not gate enable_i with ready_i.
- Scan during traffic: a change in id[] takes effect on the ready fan-out in the same cycle that follows the clock edge. No interlock exists; traffic during scan is undefined at system level but must not lock up the bus.
- Reset asserted mid-transfer: IDs return to 0. Any request with match_id=0 then matches every master.

Optional Feature:
- Macro: GON_BUS_PIPE_EN.
- Defined: enable_value is registered, updated on each posedge clk from the combinational return value, so the return latency is 1 cycle. The ready fan-out stays combinational.
- Undefined: enable_value is purely combinational, with 0-cycle latency.

Decomposition:
- Shared package gon_pkg holds:
  - default widths: GON_ID_LEN=4, GON_COL_LEN=5, GON_VALUE_LEN=32;
  - defaults GON_XBUS_NUMS=12 and GON_PE_NUMS=14.
- One natural sub-module, gon_id_match: a single ID register with scan shift, plus an equality compare producing ready_i. The bus instantiates it MASTER_NUMS times, chained.
- Row-level instance: ID_LEN=row width, PASS_LEN=column width. PE-level instance: ID_LEN=column width, PASS_LEN=1 (don't-care).

Test Plan:
- Scan load, MASTER_NUMS=4, ID_LEN=4: shift in 3,2,1,0 over 4 cycles with set_id=1 -> id[0..3]=0,1,2,3 and id_scan_out=3. With set_id=0 for 2 more cycles -> values hold.
- Unicast: IDs 0..3, ready_tag={1, 2, pass=5'h15} -> only master 2 sees ready=1 and every master sees pass_tag=5'h15. Master 2 drives {1, 32'hDEADBEEF} -> enable_value={1, 32'hDEADBEEF}.
- Multicast and priority: IDs {1,1,0,1}, match_id=1 -> masters 0, 1 and 3 ready. Masters 1 and 3 enabled with data 7 and 9 -> value=7.
- Idle: ready=0 with a matching ID -> all ready_i=0. No enables -> enable_value=0.
- Async reset: assert rst=0 between clock edges after loading IDs 5..8 -> IDs read 0 immediately and id_scan_out=0. After release, match_id=0 readies all masters.
- GON_BUS_PIPE_EN: master 0 enables data 32'h1234 at cycle N -> enable_value={1, 32'h1234} at cycle N+1. Reset clears the registered output to 0.
